// File: rtl/systolic_job_scheduler.sv
// systolic_job_scheduler
//   Accepts matrix-multiply job descriptors from two requesters. Requester 0
//   is the host core and requester 1 is the DMA engine. Each requester has its
//   own FIFO. The FIFOs are granted round-robin. A granted job is issued to
//   systolic_array_top through start_mul and the base addresses. Completion is
//   tracked through stall_mul, and a tagged done pulse goes back to the owner.
//
// Ports
//   clk, n_rst                          clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]           descriptor handshake, one bit per requester
//   req_x/w/y_addr [1:0][31:0]          descriptor base addresses
//   req_tag [1:0][TAG_W-1:0]            requester-chosen job ID
//   sched_en                            low: no new grants (in-flight job completes)
//   start_mul, x/w/y_addr               issue to the array; addresses held per job
//   stall_mul                           array busy with a multiply
//   done_valid [1:0], done_tag          1-cycle completion pulse to the owner
//   busy                                a job is granted and not yet done
//   jobs_done [15:0]                    wrapping completed-job counter
//   dbg_state [1:0]                     FSM state (0 IDLE, 1 ISSUE, 2 RUN, 3 DONE)
//
// Handshake: a descriptor transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready[i] depends only on registered FIFO
// occupancy, so a pop in the same cycle never raises it. Nothing is bypassed.
module systolic_job_scheduler #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][31:0]      req_x_addr,
   input  logic [1:0][31:0]      req_w_addr,
   input  logic [1:0][31:0]      req_y_addr,
   input  logic [1:0][TAG_W-1:0] req_tag,
   input  logic                  sched_en,
   output logic                  start_mul,
   output logic [31:0]           x_addr,
   output logic [31:0]           w_addr,
   output logic [31:0]           y_addr,
   input  logic                  stall_mul,
   output logic [1:0]            done_valid,
   output logic [TAG_W-1:0]      done_tag,
   output logic                  busy,
   output logic [15:0]           jobs_done,
   output logic [1:0]            dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   if (N < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("systolic_job_scheduler: N must be >=1, DEPTH a power of two >=2");
   end

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

   state_t r_state, w_next;

   // FIFO storage and pointers
   logic [31:0]      r_fx   [2][DEPTH];
   logic [31:0]      r_fw   [2][DEPTH];
   logic [31:0]      r_fy   [2][DEPTH];
   logic [TAG_W-1:0] r_ft   [2][DEPTH];
   logic [PW-1:0]    r_wr   [2];
   logic [PW-1:0]    r_rd   [2];
   logic [1:0]       w_full, w_ne, w_push, w_pop;

   // Job registers
   logic [31:0]      r_x, r_w, r_y;
   logic [TAG_W-1:0] r_tag;
   logic             r_owner;
   logic             r_last;
   logic [15:0]      r_jobs;

   logic             w_grant;
   logic             w_win;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         // Full when the pointers match in index bits but differ in the wrap bit.
         w_full[i] = (r_wr[i][AW] != r_rd[i][AW]) && (r_wr[i][AW-1:0] == r_rd[i][AW-1:0]);
         w_ne[i]   = (r_wr[i] != r_rd[i]);
         w_push[i] = req_valid[i] && !w_full[i];
         w_pop[i]  = w_grant && (w_win == i[0]);
      end
   end

   assign req_ready = ~w_full;

   // Both pending: take the one not granted last. One pending: take it.
   assign w_win = (w_ne[0] && w_ne[1]) ? ~r_last : w_ne[1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (w_push[i]) begin
            r_fx[i][r_wr[i][AW-1:0]] <= req_x_addr[i];
            r_fw[i][r_wr[i][AW-1:0]] <= req_w_addr[i];
            r_fy[i][r_wr[i][AW-1:0]] <= req_y_addr[i];
            r_ft[i][r_wr[i][AW-1:0]] <= req_tag[i];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < 2; i++) begin
            r_wr[i] <= '0;
            r_rd[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_push[i]) r_wr[i] <= r_wr[i] + PW'(1);
            if (w_pop[i])  r_rd[i] <= r_rd[i] + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_grant    = 1'b0;
      start_mul  = 1'b0;
      done_valid = 2'b00;
      done_tag   = '0;
      case (r_state)
         S_IDLE: begin
            if (sched_en && !stall_mul && (w_ne != 2'b00)) begin
               w_grant = 1'b1;
               w_next  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Held while the array is busy with a controller access and
            // ignoring the request; dropped once the multiply starts.
            start_mul = !stall_mul;
            if (stall_mul) w_next = S_RUN;
         end
         S_RUN: begin
            if (!stall_mul) w_next = S_DONE;
         end
         S_DONE: begin
            done_valid[r_owner] = 1'b1;
            done_tag            = r_tag;
            w_next              = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_x     <= '0;
         r_w     <= '0;
         r_y     <= '0;
         r_tag   <= '0;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_jobs  <= '0;
      end else begin
         if (w_grant) begin
            r_x     <= r_fx[w_win][r_rd[w_win][AW-1:0]];
            r_w     <= r_fw[w_win][r_rd[w_win][AW-1:0]];
            r_y     <= r_fy[w_win][r_rd[w_win][AW-1:0]];
            r_tag   <= r_ft[w_win][r_rd[w_win][AW-1:0]];
            r_owner <= w_win;
            r_last  <= w_win;
         end
         if (r_state == S_DONE) r_jobs <= r_jobs + 16'd1;
      end
   end

   assign x_addr    = r_x;
   assign w_addr    = r_w;
   assign y_addr    = r_y;
   assign busy      = (r_state != S_IDLE);
   assign jobs_done = r_jobs;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_systolic_job_scheduler.sv
module tb_systolic_job_scheduler;

   localparam int TAG_W = 4;
   localparam int DEPTH = 4;
   localparam int MUL   = 4;

   logic                  clk;
   logic                  n_rst;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][31:0]      req_x_addr, req_w_addr, req_y_addr;
   logic [1:0][TAG_W-1:0] req_tag;
   logic                  sched_en;
   logic                  start_mul;
   logic [31:0]           x_addr, w_addr, y_addr;
   logic                  stall_mul;
   logic [1:0]            done_valid;
   logic [TAG_W-1:0]      done_tag;
   logic                  busy;
   logic [15:0]           jobs_done;
   logic [1:0]            dbg_state;

   logic                  hold;
   int                    m_cnt;

   int n_checks = 0;
   int n_errs   = 0;

   logic [TAG_W-1:0] exp_q[$];
   logic [TAG_W-1:0] obs_q[$];
   logic [1:0]       obs_own_q[$];
   logic [1:0]       mon_prev;

   systolic_job_scheduler #(.N(4), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .n_rst(n_rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x_addr(req_x_addr), .req_w_addr(req_w_addr), .req_y_addr(req_y_addr),
      .req_tag(req_tag), .sched_en(sched_en),
      .start_mul(start_mul), .x_addr(x_addr), .w_addr(w_addr), .y_addr(y_addr),
      .stall_mul(stall_mul), .done_valid(done_valid), .done_tag(done_tag),
      .busy(busy), .jobs_done(jobs_done), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Array model: accepts start_mul when idle and not held by a controller
   // access, then keeps stall_mul high for MUL cycles.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stall_mul <= 1'b0;
         m_cnt     <= 0;
      end else if (stall_mul) begin
         if (m_cnt == 0) stall_mul <= 1'b0;
         else            m_cnt <= m_cnt - 1;
      end else if (start_mul && !hold) begin
         stall_mul <= 1'b1;
         m_cnt     <= MUL - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // done monitor
   always @(negedge clk) begin
      if (!n_rst) begin
         mon_prev = 2'b00;
      end else begin
         if (done_valid != 2'b00) begin
            chk("dv_onehot", {31'd0, (done_valid == 2'b01) || (done_valid == 2'b10)}, 32'd1);
            chk("dv_gap", {30'd0, mon_prev}, 32'd0);
            obs_q.push_back(done_tag);
            obs_own_q.push_back(done_valid);
         end
         mon_prev = done_valid;
      end
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      n_rst     = 1'b0;
      req_valid = 2'b00;
      sched_en  = 1'b0;
      hold      = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      obs_q.delete();
      obs_own_q.delete();
   endtask

   task automatic push(input int r, input logic [31:0] x, input logic [31:0] w,
                       input logic [31:0] y, input logic [TAG_W-1:0] t, output logic acc);
      req_valid[r]  = 1'b1;
      req_x_addr[r] = x;
      req_w_addr[r] = w;
      req_y_addr[r] = y;
      req_tag[r]    = t;
      acc = req_ready[r];
      @(negedge clk);
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_obs(input int n, input int max);
      for (int i = 0; i < max && obs_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic wait_state(input logic [1:0] s, input int max);
      for (int i = 0; i < max && dbg_state != s; i++) @(negedge clk);
   endtask

   initial begin
      logic       acc;
      logic       seen;
      logic       addr_bad;
      logic [1:0] dv;
      logic [3:0] dt;
      logic [3:0] t;
      int         n_start;
      int         n_busy;

      n_rst      = 1'b0;
      req_valid  = 2'b00;
      req_x_addr = '0;
      req_w_addr = '0;
      req_y_addr = '0;
      req_tag    = '0;
      sched_en   = 1'b0;
      hold       = 1'b0;

      // ---- reset values and single job ----
      do_reset();
      chk("rst_ready", {30'd0, req_ready}, 32'd3);
      chk("rst_start", {31'd0, start_mul}, 32'd0);
      chk("rst_dv", {30'd0, done_valid}, 32'd0);
      chk("rst_dtag", {28'd0, done_tag}, 32'd0);
      chk("rst_x", x_addr, 32'd0);
      chk("rst_w", w_addr, 32'd0);
      chk("rst_y", y_addr, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_jobs", {16'd0, jobs_done}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);

      sched_en = 1'b1;
      push(0, 32'h100, 32'h200, 32'h300, 4'd5, acc);
      chk("t1_acc", {31'd0, acc}, 32'd1);
      n_start = 0; seen = 1'b0; addr_bad = 1'b0; dv = 2'b00; dt = 4'd0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (start_mul) n_start++;
         if (busy && (x_addr != 32'h100 || w_addr != 32'h200 || y_addr != 32'h300)) addr_bad = 1'b1;
         if (done_valid != 2'b00) begin
            seen = 1'b1;
            dv   = done_valid;
            dt   = done_tag;
         end
      end
      chk("t1_seen", {31'd0, seen}, 32'd1);
      chk("t1_dv", {30'd0, dv}, 32'd1);
      chk("t1_dtag", {28'd0, dt}, 32'd5);
      chk("t1_start_cycles", n_start, 32'd1);
      chk("t1_addr_stable", {31'd0, addr_bad}, 32'd0);
      @(negedge clk);
      chk("t1_jobs", {16'd0, jobs_done}, 32'd1);
      chk("t1_busy_after", {31'd0, busy}, 32'd0);
      chk("t1_x_hold", x_addr, 32'h100);

      // ---- round-robin ----
      do_reset();
      for (int k = 0; k < 3; k++) begin
         t = 4'(k);
         push(0, 32'h1000 + k, 32'h2000 + k, 32'h3000 + k, t, acc);
      end
      for (int k = 0; k < 3; k++) begin
         t = 4'(8 + k);
         push(1, 32'h4000 + k, 32'h5000 + k, 32'h6000 + k, t, acc);
      end
      exp_q.delete();
      exp_q.push_back(4'd0); exp_q.push_back(4'd8);
      exp_q.push_back(4'd1); exp_q.push_back(4'd9);
      exp_q.push_back(4'd2); exp_q.push_back(4'd10);
      sched_en = 1'b1;
      wait_obs(6, 300);
      chk("t2_count", obs_q.size(), 32'd6);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         t = exp_q.pop_front();
         chk("t2_tag", {28'd0, obs_q.pop_front()}, {28'd0, t});
         chk("t2_owner", {30'd0, obs_own_q.pop_front()}, (t >= 4'd8) ? 32'd2 : 32'd1);
      end
      @(negedge clk);
      chk("t2_jobs", {16'd0, jobs_done}, 32'd6);

      // ---- backpressure ----
      do_reset();
      for (int k = 0; k < DEPTH + 1; k++) begin
         t = 4'(k);
         push(1, 32'h7000 + k, 32'h8000 + k, 32'h9000 + k, t, acc);
         chk("t3_acc", {31'd0, acc}, (k < DEPTH) ? 32'd1 : 32'd0);
         if (k == DEPTH - 1) chk("t3_ready_drop", {31'd0, req_ready[1]}, 32'd0);
      end
      sched_en = 1'b1;
      chk("t3_ready_grant_cyc", {31'd0, req_ready[1]}, 32'd0);
      @(negedge clk);
      chk("t3_ready_back", {31'd0, req_ready[1]}, 32'd1);
      wait_obs(4, 200);
      repeat (20) @(negedge clk);
      chk("t3_count", obs_q.size(), 32'd4);
      for (int k = 0; k < 4 && obs_q.size() > 0; k++)
         chk("t3_tag", {28'd0, obs_q.pop_front()}, k);

      // ---- blocked issue ----
      do_reset();
      sched_en = 1'b1;
      hold     = 1'b1;
      push(0, 32'hA0, 32'hB0, 32'hC0, 4'd3, acc);
      n_start = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (start_mul && dbg_state == 2'd1) n_start++;
      end
      hold = 1'b0;
      chk("t4_start_held", n_start, 32'd5);
      wait_obs(1, 50);
      chk("t4_count", obs_q.size(), 32'd1);
      if (obs_q.size() > 0) chk("t4_tag", {28'd0, obs_q[0]}, 32'd3);
      @(negedge clk);
      chk("t4_jobs", {16'd0, jobs_done}, 32'd1);

      // ---- gating ----
      do_reset();
      sched_en = 1'b1;
      push(0, 32'h600, 32'h601, 32'h602, 4'd6, acc);
      push(0, 32'h700, 32'h701, 32'h702, 4'd7, acc);
      wait_state(2'd2, 50);
      chk("t5_in_run", {30'd0, dbg_state}, 32'd2);
      sched_en = 1'b0;
      wait_obs(1, 50);
      chk("t5_first_done", obs_q.size(), 32'd1);
      if (obs_q.size() > 0) chk("t5_tag6", {28'd0, obs_q[0]}, 32'd6);
      @(negedge clk);
      n_busy = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (busy) n_busy++;
      end
      chk("t5_no_grant", n_busy, 32'd0);
      chk("t5_still_one", obs_q.size(), 32'd1);
      sched_en = 1'b1;
      wait_obs(2, 50);
      chk("t5_second_done", obs_q.size(), 32'd2);
      if (obs_q.size() > 1) chk("t5_tag7", {28'd0, obs_q[1]}, 32'd7);
      @(negedge clk);
      chk("t5_jobs", {16'd0, jobs_done}, 32'd2);

      // ---- reset during RUN with jobs queued ----
      push(0, 32'hB00, 32'hB01, 32'hB02, 4'd11, acc);
      push(0, 32'hC00, 32'hC01, 32'hC02, 4'd12, acc);
      push(0, 32'hD00, 32'hD01, 32'hD02, 4'd13, acc);
      wait_state(2'd2, 50);
      chk("t6_in_run", {30'd0, dbg_state}, 32'd2);
      obs_q.delete();
      obs_own_q.delete();
      n_rst = 1'b0;
      #1;
      chk("t6_ready", {30'd0, req_ready}, 32'd3);
      chk("t6_start", {31'd0, start_mul}, 32'd0);
      chk("t6_dv", {30'd0, done_valid}, 32'd0);
      chk("t6_dtag", {28'd0, done_tag}, 32'd0);
      chk("t6_x", x_addr, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_jobs", {16'd0, jobs_done}, 32'd0);
      chk("t6_state", {30'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      n_busy = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) n_busy++;
      end
      chk("t6_fifo_empty", n_busy, 32'd0);
      chk("t6_no_done", obs_q.size(), 32'd0);
      chk("t6_ready_after", {30'd0, req_ready}, 32'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
